// File: rtl/xip_ahbl_miss_ctrl_if.sv
// AHB-Lite slave-side signal bundle for the XIP miss controller.
`timescale 1ns/1ps
interface xip_ahbl_miss_ctrl_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/xip_ahbl_miss_ctrl.sv
// AHB-Lite read-only front-end for the QSPI XIP line cache: hit check, one line fill per miss, write rejection.
// Optional hit/miss performance counters are enabled by defining XIP_PERF_CNT_EN.
`timescale 1ns/1ps
module xip_ahbl_miss_ctrl #(
  parameter int LINE_SIZE = 16,
  parameter int NUM_LINES = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  xip_ahbl_miss_ctrl_if.slave    ahb,
  output logic [23:0]            c_A,
  output logic [23:0]            c_A_h,
  input  logic [31:0]            c_Do,
  input  logic                   c_hit,
  output logic                   c_wr,
  output logic [LINE_SIZE*8-1:0] c_line,
  output logic [23:0]            fl_addr,
  output logic                   fl_rd,
  input  logic                   fl_done,
  input  logic [LINE_SIZE*8-1:0] fl_line
`ifdef XIP_PERF_CNT_EN
  ,
  output logic [31:0]            hit_cnt,
  output logic [31:0]            miss_cnt
`endif
);

  localparam int OFF = $clog2(LINE_SIZE);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOOKUP = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_ERR1   = 3'd3;
  localparam logic [2:0] ST_ERR2   = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [23:0] addr_q, addr_d;
  logic        accept_s;
  logic        hit_s;
  logic        hreadyout_s;
  logic        hresp_s;
  logic [31:0] hrdata_s;
  logic        fl_rd_s;
  logic        c_wr_s;
  logic        unused_ok_s;

  assign accept_s    = ahb.HSEL & ahb.HTRANS[1] & ahb.HREADY;
  assign unused_ok_s = ^{ahb.HSIZE, ahb.HADDR[31:24], ahb.HTRANS[0], NUM_LINES[0]};

  // Next-state and bus response decode; responses follow the current state and cache hit.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    hreadyout_s = 1'b1;
    hresp_s     = 1'b0;
    hrdata_s    = 32'h0000_0000;
    fl_rd_s     = 1'b0;
    c_wr_s      = 1'b0;
    hit_s       = 1'b0;
    case (state_q)
      ST_IDLE, ST_ERR2: begin
        hresp_s = (state_q == ST_ERR2);
        if (accept_s && ahb.HWRITE) begin
          state_d = ST_ERR1;
        end else if (accept_s) begin
          state_d = ST_LOOKUP;
          addr_d  = ahb.HADDR[23:0];
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOOKUP: begin
        if (c_hit) begin
          hit_s    = 1'b1;
          hrdata_s = c_Do;
          if (accept_s && ahb.HWRITE) begin
            state_d = ST_ERR1;
          end else if (accept_s) begin
            state_d = ST_LOOKUP;
            addr_d  = ahb.HADDR[23:0];
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          hreadyout_s = 1'b0;
          fl_rd_s     = 1'b1;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        hreadyout_s = 1'b0;
        if (fl_done) begin
          c_wr_s  = 1'b1;
          state_d = ST_LOOKUP;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_ERR1: begin
        hreadyout_s = 1'b0;
        hresp_s     = 1'b1;
        state_d     = ST_ERR2;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and latched transfer address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= 24'h00_0000;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  assign ahb.HREADYOUT = hreadyout_s;
  assign ahb.HRESP     = hresp_s;
  assign ahb.HRDATA    = hrdata_s;
  assign c_A           = addr_q;
  assign c_A_h         = addr_q;
  assign c_wr          = c_wr_s;
  assign c_line        = fl_line;
  assign fl_addr       = {addr_q[23:OFF], {OFF{1'b0}}};
  assign fl_rd         = fl_rd_s;

`ifdef XIP_PERF_CNT_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  // Saturating counters; a hit and a fill request never occur in the same cycle.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (hit_s && (hit_cnt_q != 32'hFFFF_FFFF)) begin
      hit_cnt_d = hit_cnt_q + 32'd1;
    end else begin
      hit_cnt_d = hit_cnt_q;
    end
    if (fl_rd_s && (miss_cnt_q != 32'hFFFF_FFFF)) begin
      miss_cnt_d = miss_cnt_q + 32'd1;
    end else begin
      miss_cnt_d = miss_cnt_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= 32'h0000_0000;
      miss_cnt_q <= 32'h0000_0000;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_xip_ahbl_miss_ctrl.sv
// Directed bench for xip_ahbl_miss_ctrl with behavioural direct-mapped cache and flash line reader models.
`timescale 1ns/1ps
module tb_xip_ahbl_miss_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  xip_ahbl_miss_ctrl_if bus();
  assign bus.HREADY = bus.HREADYOUT;

  logic [23:0]  c_A, c_A_h, fl_addr;
  logic [31:0]  c_Do;
  logic         c_hit, c_wr, fl_rd, fl_done;
  logic [127:0] c_line, fl_line;
`ifdef XIP_PERF_CNT_EN
  logic [31:0]  hit_cnt, miss_cnt;
`endif

  xip_ahbl_miss_ctrl #(.LINE_SIZE(16), .NUM_LINES(16)) dut (
    .clk(clk), .rst_n(rst_n), .ahb(bus),
    .c_A(c_A), .c_A_h(c_A_h), .c_Do(c_Do), .c_hit(c_hit), .c_wr(c_wr), .c_line(c_line),
    .fl_addr(fl_addr), .fl_rd(fl_rd), .fl_done(fl_done), .fl_line(fl_line)
`ifdef XIP_PERF_CNT_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  int total = 0;
  int bad = 0;

  // Direct-mapped cache model: 16 lines x 16 bytes, index [7:4], tag [23:8].
  logic [127:0] cache_data [16];
  logic [15:0]  cache_tag [16];
  logic [15:0]  cache_vld;
  assign c_hit = cache_vld[c_A_h[7:4]] && (cache_tag[c_A_h[7:4]] == c_A_h[23:8]);
  assign c_Do  = cache_data[c_A[7:4]][{c_A[3:2], 5'b00000} +: 32];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_vld <= 16'h0000;
    end else if (c_wr) begin
      cache_vld[c_A[7:4]]  <= 1'b1;
      cache_tag[c_A[7:4]]  <= c_A[23:8];
      cache_data[c_A[7:4]] <= c_line;
    end
  end

  // Flash reader model: flash_gap idle cycles between fl_rd and the fl_done pulse.
  // Word k of a line at base B reads as 0xD0000000 | (B + 4k).
  int          flash_gap = 40;
  int          fl_cnt;
  logic        fl_busy, model_done;
  logic        spur_done = 1'b0;
  logic [23:0] fl_base;
  assign fl_done = model_done | spur_done;

  always_comb begin
    fl_line = 128'h0;
    for (int k = 0; k < 4; k++) begin
      fl_line[k*32 +: 32] = 32'hD000_0000 | {8'h00, fl_base + 24'(4 * k)};
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fl_busy    <= 1'b0;
      model_done <= 1'b0;
      fl_cnt     <= 0;
      fl_base    <= 24'h0;
    end else if (fl_rd) begin
      fl_busy    <= 1'b1;
      fl_cnt     <= flash_gap;
      fl_base    <= fl_addr;
      model_done <= 1'b0;
    end else if (model_done) begin
      model_done <= 1'b0;
    end else if (fl_busy) begin
      if (fl_cnt <= 1) begin
        model_done <= 1'b1;
        fl_busy    <= 1'b0;
      end else begin
        fl_cnt <= fl_cnt - 1;
      end
    end
  end

  // Event monitors.
  int          fl_rd_cnt = 0;
  int          c_wr_cnt = 0;
  int          c_wr_orphan = 0;
  logic [23:0] last_fl_addr = 24'h0;
  always @(posedge clk) begin
    if (fl_rd) begin
      fl_rd_cnt    <= fl_rd_cnt + 1;
      last_fl_addr <= fl_addr;
    end
    if (c_wr) c_wr_cnt <= c_wr_cnt + 1;
    if (c_wr && !fl_done) c_wr_orphan <= c_wr_orphan + 1;
  end

  task automatic bus_idle();
    bus.HSEL   = 1'b0;
    bus.HTRANS = 2'b00;
    bus.HWRITE = 1'b0;
    bus.HADDR  = 32'h0;
    bus.HSIZE  = 3'b010;
  endtask

  task automatic drive_read(input logic [31:0] a);
    bus.HSEL   = 1'b1;
    bus.HTRANS = 2'b10;
    bus.HWRITE = 1'b0;
    bus.HADDR  = a;
    bus.HSIZE  = 3'b010;
  endtask

  // Single read from an idle bus; waits = -1 when the data phase never completes.
  task automatic do_read(input logic [31:0] a, output int waits, output logic [31:0] data);
    bit done = 1'b0;
    drive_read(a);
    @(posedge clk); #1;
    bus_idle();
    waits = 0;
    data  = 32'h0;
    while (!done && waits < 300) begin
      @(negedge clk);
      if (bus.HREADYOUT) begin
        data = bus.HRDATA;
        done = 1'b1;
      end else begin
        waits++;
      end
      @(posedge clk); #1;
    end
    if (!done) waits = -1;
  endtask

  task automatic test_reset();
    bus_idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.HREADYOUT !== 1'b1) begin bad++; $display("FAIL reset_hreadyout: got %b want 1", bus.HREADYOUT); end
    total++; if (bus.HRESP !== 1'b0) begin bad++; $display("FAIL reset_hresp: got %b want 0", bus.HRESP); end
    total++; if (bus.HRDATA !== 32'h0) begin bad++; $display("FAIL reset_hrdata: got %h want 0", bus.HRDATA); end
    total++; if ({fl_rd, c_wr} !== 2'b00) begin bad++; $display("FAIL reset_strobes: got %b want 00", {fl_rd, c_wr}); end
    total++; if (c_A !== 24'h0) begin bad++; $display("FAIL reset_addr: got %h want 0", c_A); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_cold_miss();
    int waits; logic [31:0] d; int rd0, wr0;
    flash_gap = 40;
    rd0 = fl_rd_cnt; wr0 = c_wr_cnt;
    do_read(32'h0000_0104, waits, d);
    total++; if (waits != 42) begin bad++; $display("FAIL cold_waits: got %0d want 42", waits); end
    total++; if (d !== 32'hD000_0104) begin bad++; $display("FAIL cold_data: got %h want d0000104", d); end
    total++; if (fl_rd_cnt - rd0 != 1) begin bad++; $display("FAIL cold_fl_rd_count: got %0d want 1", fl_rd_cnt - rd0); end
    total++; if (last_fl_addr !== 24'h000100) begin bad++; $display("FAIL cold_fl_addr: got %h want 000100", last_fl_addr); end
    total++; if (c_wr_cnt - wr0 != 1) begin bad++; $display("FAIL cold_c_wr_count: got %0d want 1", c_wr_cnt - wr0); end
    total++; if (c_wr_orphan != 0) begin bad++; $display("FAIL cold_c_wr_align: got %0d want 0", c_wr_orphan); end
  endtask

  task automatic test_back_to_back();
    int rd0;
    rd0 = fl_rd_cnt;
    drive_read(32'h0000_0108);
    @(posedge clk); #1;
    drive_read(32'h0000_010C);
    @(negedge clk);
    total++; if (bus.HREADYOUT !== 1'b1) begin bad++; $display("FAIL b2b_first_ready: got %b want 1", bus.HREADYOUT); end
    total++; if (bus.HRDATA !== 32'hD000_0108) begin bad++; $display("FAIL b2b_first_data: got %h want d0000108", bus.HRDATA); end
    @(posedge clk); #1;
    bus_idle();
    @(negedge clk);
    total++; if (bus.HREADYOUT !== 1'b1) begin bad++; $display("FAIL b2b_second_ready: got %b want 1", bus.HREADYOUT); end
    total++; if (bus.HRDATA !== 32'hD000_010C) begin bad++; $display("FAIL b2b_second_data: got %h want d000010c", bus.HRDATA); end
    @(posedge clk); #1;
    total++; if (fl_rd_cnt != rd0) begin bad++; $display("FAIL b2b_no_fill: got %0d want %0d", fl_rd_cnt, rd0); end
  endtask

  task automatic test_tag_conflict();
    int waits; logic [31:0] d; int rd0;
    flash_gap = 5;
    rd0 = fl_rd_cnt;
    do_read(32'h0001_0104, waits, d);
    total++; if (waits != 7) begin bad++; $display("FAIL conflict_waits: got %0d want 7", waits); end
    total++; if (last_fl_addr !== 24'h010100) begin bad++; $display("FAIL conflict_fl_addr: got %h want 010100", last_fl_addr); end
    total++; if (d !== 32'hD001_0104) begin bad++; $display("FAIL conflict_data: got %h want d0010104", d); end
    do_read(32'h0000_0104, waits, d);
    total++; if (fl_rd_cnt - rd0 != 2) begin bad++; $display("FAIL refill_count: got %0d want 2", fl_rd_cnt - rd0); end
    total++; if (last_fl_addr !== 24'h000100) begin bad++; $display("FAIL refill_fl_addr: got %h want 000100", last_fl_addr); end
    total++; if (d !== 32'hD000_0104) begin bad++; $display("FAIL refill_data: got %h want d0000104", d); end
  endtask

  task automatic test_write_error();
    int rd0, wr0;
    rd0 = fl_rd_cnt; wr0 = c_wr_cnt;
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b1; bus.HADDR = 32'h0000_0200;
    @(posedge clk); #1;
    bus_idle();
    @(negedge clk);
    total++; if ({bus.HREADYOUT, bus.HRESP} !== 2'b01) begin bad++; $display("FAIL err1_resp: got %b want 01", {bus.HREADYOUT, bus.HRESP}); end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if ({bus.HREADYOUT, bus.HRESP} !== 2'b11) begin bad++; $display("FAIL err2_resp: got %b want 11", {bus.HREADYOUT, bus.HRESP}); end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if ({bus.HREADYOUT, bus.HRESP} !== 2'b10) begin bad++; $display("FAIL err_idle_resp: got %b want 10", {bus.HREADYOUT, bus.HRESP}); end
    @(posedge clk); #1;
    total++; if ((fl_rd_cnt != rd0) || (c_wr_cnt != wr0)) begin bad++; $display("FAIL err_no_fill: got rd=%0d wr=%0d want rd=%0d wr=%0d", fl_rd_cnt, c_wr_cnt, rd0, wr0); end
  endtask

  task automatic test_reset_mid_miss();
    int wr0;
    flash_gap = 40;
    drive_read(32'h0000_0300);
    @(posedge clk); #1;
    bus_idle();
    repeat (5) begin @(posedge clk); #1; end
    @(negedge clk);
    total++; if (bus.HREADYOUT !== 1'b0) begin bad++; $display("FAIL midmiss_stalled: got %b want 0", bus.HREADYOUT); end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    total++; if (bus.HREADYOUT !== 1'b1) begin bad++; $display("FAIL midmiss_async_reset: got %b want 1", bus.HREADYOUT); end
    @(posedge clk); #1;
    wr0 = c_wr_cnt;
    rst_n = 1'b1;
    spur_done = 1'b1;
    @(negedge clk);
    total++; if ({c_wr, bus.HREADYOUT} !== 2'b01) begin bad++; $display("FAIL spurious_done: got c_wr/ready=%b want 01", {c_wr, bus.HREADYOUT}); end
    @(posedge clk); #1;
    spur_done = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    total++; if (c_wr_cnt != wr0) begin bad++; $display("FAIL spurious_no_c_wr: got %0d want %0d", c_wr_cnt, wr0); end
  endtask

`ifdef XIP_PERF_CNT_EN
  task automatic test_perf();
    int waits; logic [31:0] d;
    flash_gap = 3;
    do_read(32'h0000_0400, waits, d);
    do_read(32'h0000_0400, waits, d);
    do_read(32'h0000_0404, waits, d);
    do_read(32'h0000_0408, waits, d);
    total++; if (miss_cnt !== 32'd1) begin bad++; $display("FAIL perf_miss_cnt: got %0d want 1", miss_cnt); end
    total++; if (hit_cnt !== 32'd4) begin bad++; $display("FAIL perf_hit_cnt: got %0d want 4", hit_cnt); end
  endtask
`endif

  initial begin
    bus_idle();
    test_reset();
    test_cold_miss();
    test_back_to_back();
    test_tag_conflict();
    test_write_error();
    test_reset_mid_miss();
`ifdef XIP_PERF_CNT_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
